random_arbiter: RTL and testbench

- Controller that owns one RandomicLCA instance and shares its output among N requesters (mutation, crossover, selection units).
- Sequences seeding and warm-up, then serves random words with round-robin arbitration.
- Each grant receives a fresh, never-reused LCA state.
- Sits between the LCA datapath and the genetic operator units.

---
 rtl/random_arbiter_pkg.sv | 19 +
 rtl/RandomicLCA.sv | 32 +++
 rtl/rr_pick.sv | 34 +++
 rtl/random_arbiter.sv | 96 +++++++++
 tb/tb_random_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/random_arbiter_pkg.sv
// Shared definitions for the random-word arbiter: FSM encoding, default sizes
// and the value substituted for an all-zero seed.
package random_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WARMUP = 2'd2,
        SERVE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_REQUESTERS    = 4;
    localparam int DEF_WARMUP_CYCLES = 16;

    // All-zero is a fixed point of the linear CA, so a zero seed becomes this.
    localparam int ZERO_SEED_SUB = 1;

endpackage

// File: rtl/RandomicLCA.sv
// Hybrid rule-90/150 linear cellular automaton with null boundaries.
// rst loads the seed synchronously; ce advances one generation.
module RandomicLCA #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RULE150 = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH+1:0] pad;
    logic [WIDTH-1:0] nxt;

    // pad[i] is the left neighbour of cell i, pad[i+2] the right one.
    assign pad = {1'b0, q, 1'b0};

    always_comb begin
        nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nxt[i] = pad[i] ^ pad[i+2] ^ (RULE150[i] & q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)     q <= seed;
        else if (ce) q <= nxt;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin : pick
        logic [PW:0]   sum;
        logic [PW-1:0] j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            j = sum[PW-1:0];
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/random_arbiter.sv
// Owns one RandomicLCA: seeds it, discards warm-up steps, then hands each
// round-robin winner a fresh LCA word.
module random_arbiter
    import random_arbiter_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int REQUESTERS    = DEF_REQUESTERS,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_valid,
    input  logic [WIDTH-1:0]      seed,
    output logic                  ready,
    input  logic [REQUESTERS-1:0] req,
    output logic [REQUESTERS-1:0] gnt,
    output logic [WIDTH-1:0]      data,
    output logic                  valid
);

    localparam int PW = $clog2(REQUESTERS);
    localparam int CW = $clog2(WARMUP_CYCLES + 1);

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      seed_q, lca_q;
    logic [PW-1:0]         rr_ptr, win_idx;
    logic [REQUESTERS-1:0] win_oh;
    logic                  win_any, grant, lca_rst, lca_ce;
    logic [CW-1:0]         warm_cnt;

    rr_pick #(.N(REQUESTERS)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    // A reseed strobe pre-empts arbitration in the same cycle.
    assign grant   = (state == SERVE) && !seed_valid && win_any;
    assign lca_rst = !rst || (state == LOAD);
    assign lca_ce  = (state == WARMUP) || grant;

    RandomicLCA #(.WIDTH(WIDTH)) u_lca (
        .clk  (clk),
        .rst  (lca_rst),
        .ce   (lca_ce),
        .seed (seed_q),
        .q    (lca_q)
    );

    always_comb begin
        state_nxt = state;
        if (seed_valid) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                LOAD:    state_nxt = WARMUP;
                WARMUP:  if (warm_cnt == CW'(WARMUP_CYCLES - 1)) state_nxt = SERVE;
                SERVE:   state_nxt = SERVE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_q   <= '0;
            warm_cnt <= '0;
            rr_ptr   <= '0;
            ready    <= 1'b0;
            gnt      <= '0;
            data     <= '0;
            valid    <= 1'b0;
        end else begin
            if (seed_valid)
                seed_q <= (seed == '0) ? WIDTH'(ZERO_SEED_SUB) : seed;
            if (state == LOAD)        warm_cnt <= '0;
            else if (state == WARMUP) warm_cnt <= warm_cnt + 1'b1;
            ready <= (state_nxt == SERVE);
            gnt   <= grant ? win_oh : '0;
            valid <= grant;
            if (grant) begin
                data   <= lca_q;
                rr_ptr <= (win_idx == PW'(REQUESTERS - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_random_arbiter.sv
// Bench for random_arbiter: literal vector tables, hand-written reseed/reset
// sequences and a randomized run against a cycle-level reference model.
module tb_random_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int WC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         seed_valid = 1'b0;
    logic [W-1:0] seed = '0;
    logic [N-1:0] req = '0;
    logic         ready, valid;
    logic [N-1:0] gnt;
    logic [W-1:0] data;

    int n_pass = 0;
    int n_total = 0;

    random_arbiter #(.WIDTH(W), .REQUESTERS(N), .WARMUP_CYCLES(WC)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .ready      (ready),
        .req        (req),
        .gnt        (gnt),
        .data       (data),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    // Reference model: LCA as a linear map, service phase as a countdown.
    logic [W-1:0] m_lca, m_data;
    logic [N-1:0] m_gnt;
    logic         m_valid, m_ready, m_seeded;
    int           m_ptr, m_wait;

    function automatic logic [W-1:0] lca_step(input logic [W-1:0] s);
        return (s << 1) ^ (s >> 1) ^ (s & 8'h01);
    endfunction

    task automatic model_reset();
        m_lca = '0; m_data = '0; m_gnt = '0;
        m_valid = 0; m_ready = 0; m_seeded = 0; m_ptr = 0; m_wait = 0;
    endtask

    task automatic model_step(input logic sv, input logic [W-1:0] sd, input logic [N-1:0] rq);
        m_gnt = '0;
        m_valid = 0;
        if (sv) begin
            m_lca = (sd == 0) ? 8'h01 : sd;
            repeat (WC) m_lca = lca_step(m_lca);
            m_wait = 1 + WC;
            m_seeded = 1;
            m_ready = 0;
        end else if (m_seeded && m_wait > 0) begin
            m_wait--;
            m_ready = (m_wait == 0);
        end else if (m_seeded && rq != 0) begin
            for (int k = 0; k < N; k++) begin
                int w;
                w = (m_ptr + k) % N;
                if (!m_valid && rq[w]) begin
                    m_valid = 1;
                    m_gnt = N'(1) << w;
                    m_data = m_lca;
                    m_lca = lca_step(m_lca);
                    m_ptr = (w + 1) % N;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: drive at negedge, advance model on posedge, compare just after.
    task automatic cycle(input logic sv, input logic [W-1:0] sd, input logic [N-1:0] rq);
        @(negedge clk);
        seed_valid = sv; seed = sd; req = rq;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step(sv, sd, rq);
        #1;
        check("cycle {gnt,valid,ready,data}", {19'd0, gnt, valid, ready, data},
              {19'd0, m_gnt, m_valid, m_ready, m_data});
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [W-1:0] data;
    } vec_t;

    vec_t         tbl[5];
    logic [W-1:0] seen[5];

    initial begin
        tbl[0] = '{4'b1111, 4'b0001, 8'hF0};
        tbl[1] = '{4'b1111, 4'b0010, 8'h98};
        tbl[2] = '{4'b1111, 4'b0100, 8'h7C};
        tbl[3] = '{4'b1111, 4'b1000, 8'hC6};
        tbl[4] = '{4'b1111, 4'b0001, 8'hEF};
        model_reset();

        // Reset held with all requests, then released without a seed.
        repeat (3) cycle(0, 8'h00, 4'b1111);
        check("reset outputs", {19'd0, gnt, valid, ready, data}, 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (4) cycle(0, 8'h00, 4'b1111);
        check("idle no grant", {28'd0, gnt}, 32'd0);

        // Seed and warm-up: ready after E0+1+WC.
        cycle(1, 8'hA5, 4'b0000);
        for (int i = 0; i < WC; i++) begin
            cycle(0, 8'h00, 4'b0000);
            check("ready low in warmup", {31'd0, ready}, 32'd0);
        end
        cycle(0, 8'h00, 4'b0000);
        check("ready rises", {31'd0, ready}, 32'd1);

        // All requesting: rotating grants with hand-derived LCA words.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'h00, tbl[i].req);
            check("tbl gnt", {28'd0, gnt}, {28'd0, tbl[i].gnt});
            check("tbl data", {24'd0, data}, {24'd0, tbl[i].data});
            check("tbl valid", {31'd0, valid}, 32'd1);
            seen[i] = data;
        end
        for (int i = 0; i < 5; i++)
            for (int j = i + 1; j < 5; j++)
                if (seen[i] == seen[j]) check("dup data", {24'd0, seen[j]}, {24'd0, ~seen[i]});

        // Single-cycle pulse: one grant, LCA advances once, data holds.
        cycle(0, 8'h00, 4'b0100);
        check("pulse gnt", {28'd0, gnt, 24'd0, data}, {28'b0100, 24'd0, 8'hA8});
        repeat (3) cycle(0, 8'h00, 4'b0000);
        check("data holds", {24'd0, data}, 32'h0000_00A8);
        cycle(0, 8'h00, 4'b0001);
        check("one step", {24'd0, data}, 32'h0000_0004);

        // Reseed in SERVE: no grant, ready drops, sequence restarts, ptr kept.
        cycle(1, 8'hA5, 4'b1111);
        check("reseed no grant", {27'd0, gnt, ready}, 32'd0);
        repeat (1 + WC) cycle(0, 8'h00, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'h00, 4'b1111);
            check("reseed data", {24'd0, data}, {24'd0, tbl[i].data});
        end
        check("rr_ptr continued", {28'd0, gnt}, 32'b0010);

        // Asynchronous reset mid-grant, then zero seed.
        cycle(0, 8'h00, 4'b1111);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("async reset", {27'd0, gnt, valid, ready}, 32'd0);
        cycle(0, 8'h00, 4'b1111);
        #2 rst = 1'b1;
        cycle(1, 8'h00, 4'b0000);
        repeat (1 + WC) cycle(0, 8'h00, 4'b0000);
        cycle(0, 8'h00, 4'b0010);
        check("zero seed", {28'd0, gnt, 24'd0, data}, {28'b0010, 24'd0, 8'h18});

        // Randomized traffic with occasional reseeds.
        for (int i = 0; i < 300; i++) begin
            logic         sv;
            logic [W-1:0] sd;
            logic [N-1:0] rq;
            sv = ($urandom_range(0, 39) == 0);
            sd = W'($urandom);
            if (($urandom % 8) == 0) sd = '0;
            rq = N'($urandom);
            cycle(sv, sd, rq);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
